vx_launch_ctrl: RTL and testbench

Host-side launch sequencer that sits directly upstream of the Vortex top-level wrapper. It buffers host DCR writes and, on `start`, runs one launch sequence: it holds Vortex in reset, replays the buffered writes onto the wrapper's `dcr_wr_*` port, releases reset, then watches `busy` until the kernel completes. It reports completion, timeout and the kernel cycle count.

---
 rtl/vx_launch_pkg.sv | 22 ++
 rtl/VX_fifo_queue.sv | 62 ++++++
 rtl/vx_launch_ctrl.sv | 154 +++++++++++++++
 tb/tb_vx_launch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_launch_pkg.sv
// Shared types for the Vortex launch sequencer: FSM state encoding and the
// buffered DCR write entry.
package vx_launch_pkg;

   localparam int VX_DCR_ADDR_WIDTH = 12;
   localparam int VX_DCR_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_DCR,
      ST_WAIT,
      ST_RUN,
      ST_DONE
   } launch_state_t;

   typedef struct packed {
      logic [VX_DCR_ADDR_WIDTH-1:0] addr;
      logic [VX_DCR_DATA_WIDTH-1:0] data;
   } dcr_entry_t;

endpackage

// File: rtl/VX_fifo_queue.sv
// Synchronous FIFO with an array store and a registered read port: data_out
// takes the head entry on the cycle after a pop.
module VX_fifo_queue #(
   parameter int DATAW = 1,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [DATAW-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [DATAW-1:0] data_out_reg;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == (AW+1)'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign data_out = data_out_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         data_out_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg   <= rd_ptr_reg + AW'(1);
            data_out_reg <= mem_reg[rd_ptr_reg];
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/vx_launch_ctrl.sv
// Launch sequencer for the Vortex wrapper: buffers DCR writes, then on start
// runs reset -> DCR replay -> wait for busy -> run, reporting done/timeout/cycles.
module vx_launch_ctrl
   import vx_launch_pkg::*;
#(
   parameter int DCR_ADDR_WIDTH = VX_DCR_ADDR_WIDTH,
   parameter int DCR_DATA_WIDTH = VX_DCR_DATA_WIDTH,
   parameter int QUEUE_DEPTH    = 8,
   parameter int RESET_CYCLES   = 16,
   parameter int BUSY_WAIT      = 1024,
   parameter int CNT_WIDTH      = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [DCR_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DCR_DATA_WIDTH-1:0] cmd_data,
   input  logic                      start,
   output logic                      dcr_wr_valid,
   output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
   output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
   output logic                      vx_reset,
   input  logic                      busy,
   output logic                      running,
   output logic                      done,
   output logic                      timeout,
   output logic [CNT_WIDTH-1:0]      cycles
);

   localparam int QW  = DCR_ADDR_WIDTH + DCR_DATA_WIDTH;
   localparam int RCW = $clog2(RESET_CYCLES + 1);
   localparam int WCW = $clog2(BUSY_WAIT + 1);

   launch_state_t        state_reg, state_next;
   logic [RCW-1:0]       rst_cnt_reg, rst_cnt_next;
   logic [WCW-1:0]       wait_cnt_reg, wait_cnt_next;
   logic [CNT_WIDTH-1:0] cycles_reg, cycles_next;
   logic                 timeout_reg, timeout_next;
   logic                 busy_reg;
   logic                 dcr_valid_reg;

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [QW-1:0]        fifo_dout;

   assign fifo_push = cmd_valid && !fifo_full;
   assign cmd_ready = !fifo_full;

   VX_fifo_queue #(
      .DATAW (QW),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .data_in  ({cmd_addr, cmd_data}),
      .data_out (fifo_dout),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // The queue's registered read port doubles as the write-pulse data register.
   assign dcr_wr_valid = dcr_valid_reg;
   assign dcr_wr_addr  = fifo_dout[QW-1 -: DCR_ADDR_WIDTH];
   assign dcr_wr_data  = fifo_dout[DCR_DATA_WIDTH-1:0];

   // Global reset forces the wrapper into reset combinationally, without waiting a cycle.
   assign vx_reset = reset || (state_reg == ST_IDLE) || (state_reg == ST_RESET)
                           || (state_reg == ST_DCR);
   assign running  = (state_reg == ST_RESET) || (state_reg == ST_DCR)
                  || (state_reg == ST_WAIT)  || (state_reg == ST_RUN);
   assign done     = (state_reg == ST_DONE);
   assign timeout  = timeout_reg;
   assign cycles   = cycles_reg;

   always_comb begin
      state_next    = state_reg;
      rst_cnt_next  = rst_cnt_reg;
      wait_cnt_next = wait_cnt_reg;
      cycles_next   = cycles_reg;
      timeout_next  = timeout_reg;
      fifo_pop      = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next   = ST_RESET;
               rst_cnt_next = '0;
               cycles_next  = '0;
               timeout_next = 1'b0;
            end
         end
         ST_RESET: begin
            if (rst_cnt_reg == RCW'(RESET_CYCLES - 1)) begin
               state_next = ST_DCR;
            end else begin
               rst_cnt_next = rst_cnt_reg + RCW'(1);
            end
         end
         ST_DCR: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
            end else begin
               state_next    = ST_WAIT;
               wait_cnt_next = '0;
            end
         end
         ST_WAIT: begin
            if (busy_reg) begin
               state_next = ST_RUN;
            end else if (wait_cnt_reg == WCW'(BUSY_WAIT)) begin
               state_next   = ST_DONE;
               timeout_next = 1'b1;
            end else begin
               wait_cnt_next = wait_cnt_reg + WCW'(1);
            end
         end
         ST_RUN: begin
            // The cycle that observes busy low is still counted.
            if (cycles_reg != {CNT_WIDTH{1'b1}}) begin
               cycles_next = cycles_reg + CNT_WIDTH'(1);
            end
            if (!busy_reg) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         rst_cnt_reg   <= '0;
         wait_cnt_reg  <= '0;
         cycles_reg    <= '0;
         timeout_reg   <= 1'b0;
         busy_reg      <= 1'b0;
         dcr_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rst_cnt_reg   <= rst_cnt_next;
         wait_cnt_reg  <= wait_cnt_next;
         cycles_reg    <= cycles_next;
         timeout_reg   <= timeout_next;
         busy_reg      <= busy;
         dcr_valid_reg <= fifo_pop;
      end
   end

endmodule

// File: tb/tb_vx_launch_ctrl.sv
// Bench for vx_launch_ctrl: a queue-based launch model checked every cycle,
// plus directed launches with hand-computed timing expectations.
module tb_vx_launch_ctrl;
   import vx_launch_pkg::*;

   localparam int AW = VX_DCR_ADDR_WIDTH;
   localparam int DW = VX_DCR_DATA_WIDTH;
   localparam int QD = 8;
   localparam int RC = 4;
   localparam int BW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          start = 1'b0;
   logic          dcr_wr_valid;
   logic [AW-1:0] dcr_wr_addr;
   logic [DW-1:0] dcr_wr_data;
   logic          vx_reset;
   logic          busy = 1'b0;
   logic          running;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycles;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vx_launch_ctrl #(
      .QUEUE_DEPTH  (QD),
      .RESET_CYCLES (RC),
      .BUSY_WAIT    (BW),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_addr     (cmd_addr),
      .cmd_data     (cmd_data),
      .start        (start),
      .dcr_wr_valid (dcr_wr_valid),
      .dcr_wr_addr  (dcr_wr_addr),
      .dcr_wr_data  (dcr_wr_data),
      .vx_reset     (vx_reset),
      .busy         (busy),
      .running      (running),
      .done         (done),
      .timeout      (timeout),
      .cycles       (cycles)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0, P_RST = 1, P_DCR = 2, P_WAIT = 3, P_RUN = 4, P_DONE = 5;
   int            phase = P_IDLE;
   int            rst_left = 0;
   int            waited = 0;
   longint        m_cycles = 0;
   bit            m_timeout = 1'b0;
   bit            m_wr = 1'b0;
   bit            busy_prev = 1'b0;
   bit            push_ok;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   dcr_entry_t    mq[$];
   dcr_entry_t    me;

   always @(posedge clk) begin
      push_ok = cmd_valid && (mq.size() < QD);
      m_wr = 1'b0;
      if (reset) begin
         mq.delete();
         phase = P_IDLE;
         m_cycles = 0;
         m_timeout = 1'b0;
         m_addr = '0;
         m_data = '0;
      end else begin
         case (phase)
            P_IDLE, P_DONE: if (start) begin
               phase = P_RST; rst_left = RC; m_cycles = 0; m_timeout = 1'b0;
            end
            P_RST: begin
               rst_left--;
               if (rst_left == 0) phase = P_DCR;
            end
            P_DCR: if (mq.size() > 0) begin
               me = mq.pop_front(); m_wr = 1'b1; m_addr = me.addr; m_data = me.data;
            end else begin
               phase = P_WAIT; waited = 0;
            end
            P_WAIT: if (busy_prev) phase = P_RUN;
            else begin
               waited++;
               if (waited == BW + 1) begin phase = P_DONE; m_timeout = 1'b1; end
            end
            P_RUN: begin
               if (m_cycles < (longint'(1) << CW) - 1) m_cycles++;
               if (!busy_prev) phase = P_DONE;
            end
            default: ;
         endcase
         if (push_ok) begin
            me.addr = cmd_addr; me.data = cmd_data; mq.push_back(me);
         end
      end
      busy_prev = reset ? 1'b0 : busy;
      #1;
      chk("model_cmd_ready", cmd_ready, mq.size() < QD);
      chk("model_vx_reset", vx_reset, (phase == P_IDLE) || (phase == P_RST) || (phase == P_DCR));
      chk("model_running", running, (phase >= P_RST) && (phase <= P_RUN));
      chk("model_done", done, phase == P_DONE);
      chk("model_timeout", timeout, m_timeout);
      chk("model_cycles", cycles, m_cycles);
      chk("model_wr_valid", dcr_wr_valid, m_wr);
      chk("model_wr_addr", dcr_wr_addr, m_addr);
      chk("model_wr_data", dcr_wr_data, m_data);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   dcr_entry_t tbl [3];
   int         npulse;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic launch();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      tbl[0] = '{addr: 12'h001, data: 32'h8000_0000};
      tbl[1] = '{addr: 12'h002, data: 32'h0000_0000};
      tbl[2] = '{addr: 12'h003, data: 32'h0000_0010};

      // Reset held for two cycles.
      step(); step();
      chk("rst_vx_reset", vx_reset, 1);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_done", done, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_wr_valid", dcr_wr_valid, 0);
      reset = 1'b0;
      step();

      // Launch with three buffered writes; k counts cycles after the start edge.
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_addr = tbl[i].addr; cmd_data = tbl[i].data;
         step();
      end
      cmd_valid = 1'b0;
      launch();
      chk("l1_running_k1", running, 1);
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("l1_wr_valid_k%0d", k), dcr_wr_valid, (k >= 6) && (k <= 8));
         chk($sformatf("l1_vx_reset_k%0d", k), vx_reset, k <= 8);
         if (k >= 6 && k <= 8) begin
            chk($sformatf("l1_wr_addr_k%0d", k), dcr_wr_addr, tbl[k-6].addr);
            chk($sformatf("l1_wr_data_k%0d", k), dcr_wr_data, tbl[k-6].data);
         end
         if (k < 9) step();
      end
      busy = 1'b1;
      repeat (10) step();
      busy = 1'b0;
      step();
      chk("l1_done_early", done, 0);
      step();
      chk("l1_done", done, 1);
      chk("l1_cycles", cycles, 10);
      chk("l1_timeout", timeout, 0);

      // Empty-buffer launch that times out.
      launch();
      chk("l2_cycles_cleared", cycles, 0);
      chk("l2_running", running, 1);
      for (int k = 1; k <= 39; k++) begin
         chk($sformatf("l2_no_write_k%0d", k), dcr_wr_valid, 0);
         if (k == 5) chk("l2_vx_reset_dcr", vx_reset, 1);
         if (k == 6) chk("l2_vx_reset_wait", vx_reset, 0);
         if (k == 38) chk("l2_done_early", done, 0);
         if (k == 39) begin
            chk("l2_done", done, 1);
            chk("l2_timeout", timeout, 1);
            chk("l2_cycles", cycles, 0);
         end
         if (k < 39) step();
      end

      // Backpressure: nine back-to-back pushes into an eight-entry buffer.
      cmd_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmd_addr = AW'(12'h100 + i); cmd_data = DW'(i * 3);
         step();
      end
      chk("bp_full_after_8", cmd_ready, 0);
      cmd_addr = 12'h108; cmd_data = 32'hDEAD_BEEF;
      launch();
      npulse = 0;
      for (int k = 1; k <= 15; k++) begin
         if (k <= 5) chk($sformatf("bp_ready_low_k%0d", k), cmd_ready, 0);
         if (k == 6) chk("bp_ready_after_pop", cmd_ready, 1);
         if (k == 14) begin
            chk("bp_last_addr", dcr_wr_addr, 12'h108);
            chk("bp_last_data", dcr_wr_data, 32'hDEAD_BEEF);
         end
         npulse += int'(dcr_wr_valid);
         if (k < 15) begin
            step();
            if (k == 6) cmd_valid = 1'b0;
         end
      end
      chk("bp_pulse_count", npulse, 9);
      chk("bp_vx_reset_wait", vx_reset, 0);

      // Busy for six cycles with a start pulse during RUN that must be ignored.
      for (int j = 0; j < 6; j++) begin
         busy = 1'b1;
         start = (j == 3);
         step();
      end
      busy = 1'b0; start = 1'b0;
      step(); step();
      chk("rs_done", done, 1);
      chk("rs_cycles", cycles, 6);
      chk("rs_timeout", timeout, 0);

      // Global reset in RUN with two entries buffered.
      launch();
      repeat (5) step();
      busy = 1'b1;
      step();
      cmd_valid = 1'b1; cmd_addr = 12'h0AA; cmd_data = 32'h1111;
      step();
      cmd_addr = 12'h0BB; cmd_data = 32'h2222;
      step();
      cmd_valid = 1'b0;
      repeat (3) step();
      chk("gr_cycles_before", cycles, 4);
      chk("gr_vx_reset_before", vx_reset, 0);
      reset = 1'b1;
      #1;
      chk("gr_vx_reset_immediate", vx_reset, 1);
      step();
      chk("gr_running", running, 0);
      chk("gr_done", done, 0);
      chk("gr_cycles", cycles, 0);
      chk("gr_vx_reset", vx_reset, 1);
      chk("gr_cmd_ready", cmd_ready, 1);
      reset = 1'b0; busy = 1'b0;
      launch();
      npulse = 0;
      for (int k = 1; k <= 7; k++) begin
         npulse += int'(dcr_wr_valid);
         if (k == 6) chk("gr_empty_wait", vx_reset, 0);
         if (k < 7) step();
      end
      chk("gr_flushed_no_writes", npulse, 0);
      step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
